// File: rtl/aes_key_sched_ctrl_pkg.sv
// aes_pkg: shared AES constants, word type, controller state encoding and the
// GF(2^8) xtime helper used to step the round constant.
// Optional feature macro used elsewhere in this slice: KEY_SCHED_STREAM_EN.
package aes_pkg;

  localparam int NK     = 4;
  localparam int NR     = 10;
  localparam int NWORDS = 44;

  typedef logic [31:0] aes_word_t;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-schedule bus: start/key load, status flags and the round-key read port.
// KEY_SCHED_STREAM_EN adds the per-round key stream outputs.
interface aes_key_sched_ctrl_if;

  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
`ifdef KEY_SCHED_STREAM_EN
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
`endif

  // Key-load / round-datapath side.
  modport master (
    output start, key_in, rd_round,
`ifdef KEY_SCHED_STREAM_EN
    input  rk_valid, rk_round, rk_data,
`endif
    input  busy, done, keys_valid, rd_key
  );

  // Key-schedule controller side.
  modport slave (
    input  start, key_in, rd_round,
`ifdef KEY_SCHED_STREAM_EN
    output rk_valid, rk_round, rk_data,
`endif
    output busy, done, keys_valid, rd_key
  );

endinterface

// File: rtl/aes_key_sched_ctrl_sbox.sv
// aes_sbox: combinational AES forward S-box. The multiplicative inverse is
// formed as data^254 by square-and-multiply, followed by the affine map, so no
// lookup table is stored. Reusable by the cipher SubBytes stage.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] inv;

  // Inverse (0 maps to 0 naturally) then affine transform with constant 0x63.
  always_comb begin
    inv = data;
    for (int k = 0; k < 6; k++) begin
      inv = gf_mul(gf_mul(inv, inv), data);
    end
    inv = gf_mul(inv, inv);
    sub = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-128 key expansion, one word per clock
// through a shared 4-byte S-box path, with an 11-entry round-key buffer and a
// registered read port. KEY_SCHED_STREAM_EN adds a per-round key stream.
module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_sched_ctrl_if.slave  bus
);
  import aes_pkg::*;

  state_t    state;
  logic [5:0] idx;
  logic [7:0] rcon;
  logic       busy;
  logic       done;
  logic       keys_valid;
  logic [127:0] rd_key;
  aes_word_t  w_buf [NWORDS];

  aes_word_t  prev;
  aes_word_t  back4;
  aes_word_t  rot;
  aes_word_t  sub;
  aes_word_t  t;
  aes_word_t  next_w;
  logic [5:0] rd_base;

`ifdef KEY_SCHED_STREAM_EN
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  assign bus.rk_valid = rk_valid;
  assign bus.rk_round = rk_round;
  assign bus.rk_data  = rk_data;
`endif

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.keys_valid = keys_valid;
  assign bus.rd_key     = rd_key;

  // Next expanded word w[idx] from w[idx-1] and w[idx-4].
  always_comb begin
    prev   = w_buf[idx - 6'd1];
    back4  = w_buf[idx - 6'd4];
    rot    = {prev[23:0], prev[31:24]};
    t      = (idx[1:0] == 2'b00) ? (sub ^ {rcon, 24'h0}) : prev;
    next_w = back4 ^ t;
  end

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data (rot[8*b +: 8]),
      .sub  (sub[8*b +: 8])
    );
  end

  // Controller FSM: key load, word generation, status flags and key stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      idx        <= 6'd0;
      rcon       <= 8'h00;
`ifdef KEY_SCHED_STREAM_EN
      rk_valid   <= 1'b0;
      rk_round   <= 4'd0;
      rk_data    <= 128'h0;
`endif
    end else begin
      done <= 1'b0;
`ifdef KEY_SCHED_STREAM_EN
      rk_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            w_buf[0]   <= bus.key_in[127:96];
            w_buf[1]   <= bus.key_in[95:64];
            w_buf[2]   <= bus.key_in[63:32];
            w_buf[3]   <= bus.key_in[31:0];
            idx        <= 6'd4;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
`ifdef KEY_SCHED_STREAM_EN
            rk_valid   <= 1'b1;
            rk_round   <= 4'd0;
            rk_data    <= bus.key_in;
`endif
          end
        end
        EXPAND: begin
          w_buf[idx] <= next_w;
          idx        <= idx + 6'd1;
          if (idx[1:0] == 2'b00) rcon <= xtime(rcon);
`ifdef KEY_SCHED_STREAM_EN
          if (idx[1:0] == 2'b11) begin
            rk_valid <= 1'b1;
            rk_round <= idx[5:2];
            rk_data  <= {w_buf[idx - 6'd3], w_buf[idx - 6'd2], prev, next_w};
          end
`endif
          if (idx == 6'(NWORDS - 1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_base = {rd_round_q(), 2'b00};

  function automatic logic [3:0] rd_round_q();
    return bus.rd_round;
  endfunction

  // Registered round-key read; indices past the last round return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key <= 128'h0;
    end else if (bus.rd_round <= 4'(NR)) begin
      rd_key <= {w_buf[rd_base], w_buf[rd_base + 6'd1],
                 w_buf[rd_base + 6'd2], w_buf[rd_base + 6'd3]};
    end else begin
      rd_key <= 128'h0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: random and FIPS-197 keys expanded by the DUT and
// compared with a reference key expansion computed from the AES definition.
// Build with KEY_SCHED_STREAM_EN defined to also check the round-key stream.
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  aes_key_sched_ctrl_if bus ();

  aes_key_sched_ctrl #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nVectors     = 0;
  int nMiscompares = 0;
  logic [31:0] mw [44];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int k = 0; k < 8; k++) if (b[k]) prod = prod ^ (16'(a) << k);
    for (int k = 15; k >= 8; k--) if (prod[k]) prod = prod ^ (16'h11b << (k - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] refSbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    inv = 8'h00;
    c   = 8'h63;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++) if (refMul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int j = 0; j < 8; j++)
      s[j] = inv[j] ^ inv[(j + 4) % 8] ^ inv[(j + 5) % 8] ^ inv[(j + 6) % 8] ^ inv[(j + 7) % 8] ^ c[j];
    return s;
  endfunction

  task automatic buildModel(input logic [127:0] key);
    logic [7:0]  rc [10];
    logic [31:0] tmp;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int k = 0; k < 4; k++) mw[k] = key[127 - 32*k -: 32];
    for (int k = 4; k < 44; k++) begin
      tmp = mw[k-1];
      if (k % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {refSbox(tmp[31:24]), refSbox(tmp[23:16]), refSbox(tmp[15:8]), refSbox(tmp[7:0])};
        tmp = tmp ^ {rc[k/4 - 1], 24'h0};
      end
      mw[k] = mw[k-4] ^ tmp;
    end
  endtask

  function automatic logic [127:0] modelRound(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // Start an expansion; optionally re-pulse start with another key or abort by reset.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] otherKey,
                               input bit rePulse, input int abortAt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = key;
    @(posedge clk); #1;
    checkOutput("busy_at_start", bus.busy, 1);
    checkOutput("kv_at_start", bus.keys_valid, 0);
`ifdef KEY_SCHED_STREAM_EN
    checkOutput("rk_valid_r0", bus.rk_valid, 1);
    checkOutput("rk_round_r0", bus.rk_round, 0);
    checkOutput("rk_data_r0", bus.rk_data, key);
`endif
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start  = rePulse && (c == 5 || c == 40);
      bus.key_in = rePulse ? otherKey : key;
      rst        = (c == abortAt);
      @(posedge clk); #1;
      if (c == abortAt) begin
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_kv", bus.keys_valid, 0);
        checkOutput("abort_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      checkOutput($sformatf("busy_c%0d", c), bus.busy, (c < 40));
      checkOutput($sformatf("done_c%0d", c), bus.done, (c == 40));
`ifdef KEY_SCHED_STREAM_EN
      checkOutput($sformatf("rk_valid_c%0d", c), bus.rk_valid, (c % 4 == 0));
      if (c % 4 == 0) begin
        checkOutput($sformatf("rk_round_c%0d", c), bus.rk_round, 128'(c / 4));
        checkOutput($sformatf("rk_data_c%0d", c), bus.rk_data, modelRound(c / 4));
      end
`endif
    end
    checkOutput("kv_after_done", bus.keys_valid, 1);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    checkOutput("done_pulse_end", bus.done, 0);
    checkOutput("busy_stays_low", bus.busy, 0);
  endtask

  task automatic readRound(input int r, input logic [127:0] exp, input string tag);
    @(negedge clk);
    bus.rd_round = 4'(r);
    @(posedge clk); #1;
    checkOutput(tag, bus.rd_key, exp);
  endtask

  task automatic readAllRounds();
    for (int r = 0; r <= 10; r++) readRound(r, modelRound(r), $sformatf("rd_round%0d", r));
  endtask

  initial begin
    logic [127:0] rk;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = 128'h0;
    bus.rd_round = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_kv", bus.keys_valid, 0);
    checkOutput("reset_rd_key", bus.rd_key, 0);
`ifdef KEY_SCHED_STREAM_EN
    checkOutput("reset_rk_valid", bus.rk_valid, 0);
    checkOutput("reset_rk_data", bus.rk_data, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] FIPS-197 key with ignored restarts");
    buildModel(FIPS_KEY);
    applyStimulus(FIPS_KEY, 128'hdeadbeef_00112233_44556677_8899aabb, 1'b1, 0);
    readAllRounds();
    readRound(1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_round1");
    readRound(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_round10");

    $display("[TB] all-zero key");
    buildModel(128'h0);
    applyStimulus(128'h0, 128'h0, 1'b0, 0);
    readRound(0, 128'h0, "zero_round0");
    readRound(1, 128'h62636363626363636263636362636363, "zero_round1");
    readRound(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_round10");

    $display("[TB] reset abort mid-expansion");
    rk = {$urandom, $urandom, $urandom, $urandom};
    buildModel(rk);
    applyStimulus(rk, 128'h0, 1'b0, 20);

    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_beats_start", bus.busy, 0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;

    $display("[TB] random keys");
    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      buildModel(rk);
      applyStimulus(rk, 128'h0, 1'b0, 0);
      readAllRounds();
    end

    $display("[TB] out-of-range reads and read latency");
    for (int r = 11; r <= 15; r++) readRound(r, 128'h0, $sformatf("rd_high%0d", r));
    readRound(1, modelRound(1), "lat_first");
    @(negedge clk);
    bus.rd_round = 4'd10;
    #1;
    checkOutput("lat_hold", bus.rd_key, modelRound(1));
    @(posedge clk); #1;
    checkOutput("lat_update", bus.rd_key, modelRound(10));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
